// File: rtl/gate_sensor_decoder.sv
// Gate sensor front end: synchronizes and debounces two light-beam sensors and
// decodes the beam-break order into single-cycle entry/exit/abort pulses.
module gate_sensor_decoder #(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic clk,
    input  logic clr,
    input  logic sens_a,
    input  logic sens_b,
    output logic ent,
    output logic ext,
    output logic err,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR
    } state_t;

    logic [1:0] sens_raw;
    logic [1:0] deb_lvl;
    logic [1:0] lvl_ab;

    assign sens_raw = {sens_b, sens_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic       meta_q;
            logic       sync_q;
            logic       deb_q;
            logic       deb_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            // The counter holds the number of mismatching samples seen so far,
            // so the level flips on the sample that brings it to DEB_CYCLES.
            always_comb begin
                deb_d = deb_q;
                cnt_d = 8'd0;
                if (sync_q != deb_q) begin
                    if (cnt_q == 8'(DEB_CYCLES - 1)) begin
                        deb_d = sync_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!clr) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    deb_q  <= 1'b0;
                    cnt_q  <= 8'd0;
                end else begin
                    meta_q <= sens_raw[gi];
                    sync_q <= meta_q;
                    deb_q  <= deb_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign deb_lvl[gi] = deb_q;
        end
    endgenerate

    // Ordered {a, b} so case labels read like the beam pattern.
    assign lvl_ab = {deb_lvl[0], deb_lvl[1]};

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic       ent_q, ent_d;
    logic       ext_q, ext_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        ent_d   = 1'b0;
        ext_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: case (lvl_ab)
                2'b10:   state_d = IN_A;
                2'b01:   state_d = OUT_B;
                2'b11:   begin state_d = WAIT_CLR; err_d = 1'b1; end
                default: ;
            endcase
            IN_A: case (lvl_ab)
                2'b11:   state_d = IN_AB;
                2'b01:   state_d = IN_B;
                2'b00:   state_d = IDLE;
                default: ;
            endcase
            IN_AB: case (lvl_ab)
                2'b10:   state_d = IN_A;
                2'b01:   state_d = IN_B;
                2'b00:   begin state_d = WAIT_CLR; err_d = 1'b1; end
                default: ;
            endcase
            IN_B: case (lvl_ab)
                2'b00:   begin state_d = IDLE; ent_d = 1'b1; end
                2'b11:   state_d = IN_AB;
                2'b10:   begin state_d = WAIT_CLR; err_d = 1'b1; end
                default: ;
            endcase
            OUT_B: case (lvl_ab)
                2'b11:   state_d = OUT_BA;
                2'b10:   state_d = OUT_A;
                2'b00:   state_d = IDLE;
                default: ;
            endcase
            OUT_BA: case (lvl_ab)
                2'b01:   state_d = OUT_B;
                2'b10:   state_d = OUT_A;
                2'b00:   begin state_d = WAIT_CLR; err_d = 1'b1; end
                default: ;
            endcase
            OUT_A: case (lvl_ab)
                2'b00:   begin state_d = IDLE; ext_d = 1'b1; end
                2'b11:   state_d = OUT_BA;
                2'b01:   begin state_d = WAIT_CLR; err_d = 1'b1; end
                default: ;
            endcase
            WAIT_CLR: if (lvl_ab == 2'b00) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // A stalled passage overrides whatever the sensors asked for this cycle.
        if (state_q != IDLE && state_q != WAIT_CLR && dwell_q == 8'(TIMEOUT - 1)) begin
            state_d = WAIT_CLR;
            ent_d   = 1'b0;
            ext_d   = 1'b0;
            err_d   = 1'b1;
        end

        if (state_d != state_q || state_d == IDLE || state_d == WAIT_CLR) begin
            dwell_d = 8'd0;
        end else begin
            dwell_d = dwell_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            dwell_q <= 8'd0;
            ent_q   <= 1'b0;
            ext_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            ent_q   <= ent_d;
            ext_q   <= ext_d;
            err_q   <= err_d;
        end
    end

    assign ent  = ent_q;
    assign ext  = ext_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder with DEB_CYCLES=4, TIMEOUT=20:
// inputs change 1 time unit after a rising edge, outputs are sampled there too.
module tb_gate_sensor_decoder;

    logic clk = 1'b0;
    logic clr;
    logic sens_a;
    logic sens_b;
    logic ent, ext, err, busy;

    int errors = 0;
    int checks = 0;
    int ent_cnt, ext_cnt, err_cnt, busy_cnt, multi_cnt;

    gate_sensor_decoder #(.DEB_CYCLES(4), .TIMEOUT(20)) dut (
        .clk    (clk),
        .clr    (clr),
        .sens_a (sens_a),
        .sens_b (sens_b),
        .ent    (ent),
        .ext    (ext),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        ent_cnt = 0; ext_cnt = 0; err_cnt = 0; busy_cnt = 0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ent)  ent_cnt++;
            if (ext)  ext_cnt++;
            if (err)  err_cnt++;
            if (busy) busy_cnt++;
            if (int'(ent) + int'(ext) + int'(err) > 1) multi_cnt++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; sens_a = 1'b1; sens_b = 1'b1;
        step(3);
        checks++; if (ent !== 1'b0)  begin errors++; $display("FAIL reset_ent: got %b want 0", ent); end
        checks++; if (ext !== 1'b0)  begin errors++; $display("FAIL reset_ext: got %b want 0", ext); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        sens_a = 1'b0; sens_b = 1'b0; clr = 1'b1;
        clear_counts();
        step(12);
        checks++; if (busy_cnt + err_cnt != 0) begin errors++; $display("FAIL reset_idle: activity=%0d want 0", busy_cnt + err_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_entry();
        clear_counts();
        sens_a = 1'b1;
        step(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL entry_busy_early: got %b want 0", busy); end
        step(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL entry_busy_rise: got %b want 1", busy); end
        step(3);  sens_b = 1'b1;
        step(10); sens_a = 1'b0;
        step(10); sens_b = 1'b0;
        step(6);
        checks++; if (ent !== 1'b0) begin errors++; $display("FAIL entry_ent_early: got %b want 0", ent); end
        step(1);
        checks++; if (ent !== 1'b1) begin errors++; $display("FAIL entry_ent_pulse: got %b want 1", ent); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL entry_busy_fall: got %b want 0", busy); end
        step(10);
        checks++; if (ent_cnt != 1) begin errors++; $display("FAIL entry_ent_count: got %0d want 1", ent_cnt); end
        checks++; if (ext_cnt + err_cnt != 0) begin errors++; $display("FAIL entry_other_pulses: got %0d want 0", ext_cnt + err_cnt); end
        $display("test_entry done: ent=%0d ext=%0d err=%0d", ent_cnt, ext_cnt, err_cnt);
    endtask

    task automatic test_exit();
        clear_counts();
        sens_b = 1'b1;
        step(10); sens_a = 1'b1;
        step(10); sens_b = 1'b0;
        step(10); sens_a = 1'b0;
        step(6);
        checks++; if (ext !== 1'b0) begin errors++; $display("FAIL exit_ext_early: got %b want 0", ext); end
        step(1);
        checks++; if (ext !== 1'b1) begin errors++; $display("FAIL exit_ext_pulse: got %b want 1", ext); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exit_busy_fall: got %b want 0", busy); end
        step(10);
        checks++; if (ext_cnt != 1) begin errors++; $display("FAIL exit_ext_count: got %0d want 1", ext_cnt); end
        checks++; if (ent_cnt + err_cnt != 0) begin errors++; $display("FAIL exit_other_pulses: got %0d want 0", ent_cnt + err_cnt); end
        $display("test_exit done: ent=%0d ext=%0d err=%0d", ent_cnt, ext_cnt, err_cnt);
    endtask

    task automatic test_bounce();
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            sens_a = ~sens_a;
            step(2);
        end
        sens_a = 1'b0;
        step(20);
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL bounce_busy: got %0d cycles want 0", busy_cnt); end
        checks++; if (ent_cnt + ext_cnt + err_cnt != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", ent_cnt + ext_cnt + err_cnt); end
        $display("test_bounce done: busy_cycles=%0d", busy_cnt);
    endtask

    task automatic test_backoff();
        clear_counts();
        sens_a = 1'b1;
        step(10); sens_a = 1'b0;
        step(20);
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL backoff_busy: got %0d cycles want 10", busy_cnt); end
        checks++; if (ent_cnt + ext_cnt + err_cnt != 0) begin errors++; $display("FAIL backoff_pulses: got %0d want 0", ent_cnt + ext_cnt + err_cnt); end
        $display("test_backoff done: busy_cycles=%0d", busy_cnt);
    endtask

    task automatic test_timeout();
        clear_counts();
        sens_a = 1'b1;
        step(7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_rise: got %b want 1", busy); end
        step(19);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_early: got %b want 0", err); end
        step(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err_pulse: got %b want 1", err); end
        step(1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_width: got %b want 0", err); end
        step(12); sens_a = 1'b0;
        step(6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_wait_clr: got %b want 1", busy); end
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_fall: got %b want 0", busy); end
        step(5);
        checks++; if (err_cnt != 1 || ent_cnt != 0) begin errors++; $display("FAIL timeout_counts: err=%0d ent=%0d want 1/0", err_cnt, ent_cnt); end
        $display("test_timeout done: err=%0d ent=%0d", err_cnt, ent_cnt);
    endtask

    task automatic test_malformed();
        clear_counts();
        sens_a = 1'b1;
        step(10); sens_b = 1'b1;
        step(10); sens_a = 1'b0; sens_b = 1'b0;
        step(6);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL malformed_err_early: got %b want 0", err); end
        step(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL malformed_err_pulse: got %b want 1", err); end
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL malformed_wait_exit: got %b want 0", busy); end
        step(8);
        checks++; if (err_cnt != 1 || ent_cnt != 0) begin errors++; $display("FAIL malformed_counts: err=%0d ent=%0d want 1/0", err_cnt, ent_cnt); end
        $display("test_malformed done: err=%0d", err_cnt);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        sens_a = 1'b1;
        step(10); sens_b = 1'b1;
        step(10); sens_a = 1'b0;
        step(10); sens_b = 1'b0;
        step(1);  sens_a = 1'b1;
        step(6);
        checks++; if (ent !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first_ent: ent=%b busy=%b want 1/0", ent, busy); end
        step(1);
        checks++; if (ent !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: ent=%b busy=%b want 0/1", ent, busy); end
        step(2);  sens_b = 1'b1;
        step(10); sens_a = 1'b0;
        step(10); sens_b = 1'b0;
        step(10);
        checks++; if (ent_cnt != 2) begin errors++; $display("FAIL b2b_ent_count: got %0d want 2", ent_cnt); end
        $display("test_back_to_back done: ent=%0d", ent_cnt);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        sens_a = 1'b1;
        step(10); sens_b = 1'b1;
        step(10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_in_ab: got %b want 1", busy); end
        clr = 1'b0;
        step(1);
        checks++; if ({ent, ext, err, busy} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs: got %b want 0000", {ent, ext, err, busy}); end
        clr = 1'b1;
        step(6);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_early: err=%b busy=%b want 0/0", err, busy); end
        step(1);
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_err: err=%b busy=%b want 1/1", err, busy); end
        step(3);
        sens_a = 1'b0; sens_b = 1'b0;
        step(10);
        checks++; if (err_cnt != 1 || ent_cnt + ext_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_counts: err=%0d ent+ext=%0d busy=%b want 1/0/0", err_cnt, ent_cnt + ext_cnt, busy);
        end
        $display("test_reset_mid done: err=%0d", err_cnt);
    endtask

    task automatic test_exclusive();
        checks++; if (multi_cnt != 0) begin errors++; $display("FAIL exclusive_pulses: got %0d cycles want 0", multi_cnt); end
    endtask

    initial begin
        clr = 1'b0; sens_a = 1'b0; sens_b = 1'b0;
        multi_cnt = 0;
        clear_counts();
        test_reset();
        test_entry();
        test_exit();
        test_bounce();
        test_backoff();
        test_timeout();
        test_malformed();
        test_back_to_back();
        test_reset_mid();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
